// File: rtl/floo_atop_id_allocator_pkg.sv
// Shared types for the atomic-transaction ID allocator: per-slot state encoding
// and ID sizing helpers.
package floo_atop_id_allocator_pkg;

   typedef enum logic [1:0] {
      FREE    = 2'b00,
      WAIT_B  = 2'b01,
      WAIT_R  = 2'b10,
      WAIT_BR = 2'b11
   } atop_slot_e;

   // Wide enough to hold any incoming ID, so range checks are width-safe.
   localparam int unsigned MaxIdWidth = 8;
   typedef logic [MaxIdWidth-1:0] atop_wide_id_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/floo_atop_id_allocator_slot.sv
// One atomic ID slot: tracks which of B and R are still owed, and flags events
// that do not fit the current state.
module floo_atop_slot
   import floo_atop_id_allocator_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ack,
   input  logic       has_r,
   input  logic       b_free,
   input  logic       r_free,
   output atop_slot_e state,
   output logic       busy,
   output logic       err,
   output logic       enter,
   output logic       retire
);

   atop_slot_e state_q, state_d;

   // Any illegal event on this slot leaves the state untouched.
   always_comb begin
      state_d = state_q;
      err     = 1'b0;
      case (state_q)
         FREE: begin
            if (b_free || r_free) err = 1'b1;
            else if (ack)         state_d = has_r ? WAIT_BR : WAIT_B;
         end
         WAIT_B: begin
            if (r_free || ack) err = 1'b1;
            else if (b_free)   state_d = FREE;
         end
         WAIT_R: begin
            if (b_free || ack) err = 1'b1;
            else if (r_free)   state_d = FREE;
         end
         WAIT_BR: begin
            if (ack)                     err = 1'b1;
            else if (b_free && r_free)   state_d = FREE;
            else if (b_free)             state_d = WAIT_R;
            else if (r_free)             state_d = WAIT_B;
         end
         default: state_d = FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FREE;
      else        state_q <= state_d;
   end

   assign state  = state_q;
   assign busy   = (state_q != FREE);
   assign enter  = (state_q == FREE) && (state_d != FREE);
   assign retire = (state_q != FREE) && (state_d == FREE);

endmodule

// File: rtl/floo_atop_id_allocator.sv
// Hands out the lowest free atomic AXI ID, holds it across AW stalls and
// returns it to the pool once every expected B/R response has come back.
module floo_atop_id_allocator
   import floo_atop_id_allocator_pkg::*;
#(
   parameter  int unsigned MaxAtomicTxns = 4,
   localparam int unsigned IdWidth       = idx_width(MaxAtomicTxns),
   localparam int unsigned CntWidth      = idx_width(MaxAtomicTxns + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     alloc_req_i,
   input  logic                     alloc_has_r_i,
   input  logic                     alloc_ack_i,
   output logic                     alloc_gnt_o,
   output logic [IdWidth-1:0]       alloc_id_o,
   input  logic                     b_free_i,
   input  logic [IdWidth-1:0]       b_free_id_i,
   input  logic                     r_free_i,
   input  logic [IdWidth-1:0]       r_free_id_i,
   output logic [MaxAtomicTxns-1:0] busy_o,
   output logic [CntWidth-1:0]      outstanding_o,
   output logic                     err_o
);

   localparam int unsigned N = MaxAtomicTxns;

   atop_slot_e        slot_state [N];
   logic [N-1:0]      slot_busy, slot_err, slot_enter, slot_retire;
   logic [N-1:0]      slot_ack, slot_b, slot_r;
   logic              any_free;
   logic [IdWidth-1:0] cand_id;
   logic              lock_q;
   logic [IdWidth-1:0] lock_id_q;
   logic              ack_ok, ack_bad, b_oor, r_oor;
   logic [CntWidth-1:0] cnt_q, cnt_d, n_enter, n_retire;
   logic              err_q;

   // Lowest-index free slot, from registered state only.
   always_comb begin
      any_free = 1'b0;
      cand_id  = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (slot_state[i] == FREE) begin
            any_free = 1'b1;
            cand_id  = IdWidth'(i);
         end
      end
   end

   assign alloc_gnt_o = lock_q | any_free;
   assign alloc_id_o  = lock_q ? lock_id_q : cand_id;

   assign ack_ok  = alloc_ack_i & alloc_req_i & alloc_gnt_o;
   assign ack_bad = alloc_ack_i & ~ack_ok;
   assign b_oor   = b_free_i & (atop_wide_id_t'(b_free_id_i) >= atop_wide_id_t'(N));
   assign r_oor   = r_free_i & (atop_wide_id_t'(r_free_id_i) >= atop_wide_id_t'(N));

   for (genvar g = 0; g < N; g++) begin : gen_slot
      assign slot_ack[g] = ack_ok   && (alloc_id_o  == IdWidth'(g));
      assign slot_b[g]   = b_free_i && (b_free_id_i == IdWidth'(g));
      assign slot_r[g]   = r_free_i && (r_free_id_i == IdWidth'(g));

      floo_atop_slot i_slot (
         .clk    (clk_i),
         .rst_n  (rst_ni),
         .ack    (slot_ack[g]),
         .has_r  (alloc_has_r_i),
         .b_free (slot_b[g]),
         .r_free (slot_r[g]),
         .state  (slot_state[g]),
         .busy   (slot_busy[g]),
         .err    (slot_err[g]),
         .enter  (slot_enter[g]),
         .retire (slot_retire[g])
      );
   end

   always_comb begin
      n_enter  = '0;
      n_retire = '0;
      for (int i = 0; i < int'(N); i++) begin
         n_enter  = n_enter  + CntWidth'(slot_enter[i]);
         n_retire = n_retire + CntWidth'(slot_retire[i]);
      end
      cnt_d = cnt_q + n_enter - n_retire;
   end

   // A stalled AW keeps its ID even if a lower slot frees up meanwhile.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         if (alloc_ack_i || !alloc_req_i) begin
            lock_q <= 1'b0;
         end else if (alloc_gnt_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= alloc_id_o;
         end
         cnt_q <= cnt_d;
         err_q <= ack_bad | b_oor | r_oor | (|slot_err);
      end
   end

   assign busy_o        = slot_busy;
   assign outstanding_o = cnt_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_floo_atop_id_allocator.sv
// Bench for the atomic ID allocator: directed scenarios plus random traffic,
// all compared against a needs-B/needs-R reference model.
module tb_floo_atop_id_allocator;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       req = 1'b0, has_r = 1'b0, ack = 1'b0;
   logic       bf = 1'b0, rf = 1'b0;
   logic [1:0] bid = '0, rid = '0;
   logic       gnt;
   logic [1:0] id;
   logic [3:0] busy;
   logic [2:0] outst;
   logic       err;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   // Reference model: which responses each ID still owes.
   bit nb [N];
   bit nr [N];
   bit m_lock;
   int m_lock_id;
   bit m_err;

   floo_atop_id_allocator #(.MaxAtomicTxns(N)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .alloc_req_i   (req),
      .alloc_has_r_i (has_r),
      .alloc_ack_i   (ack),
      .alloc_gnt_o   (gnt),
      .alloc_id_o    (id),
      .b_free_i      (bf),
      .b_free_id_i   (bid),
      .r_free_i      (rf),
      .r_free_id_i   (rid),
      .busy_o        (busy),
      .outstanding_o (outst),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_busy(input int i);
      return nb[i] || nr[i];
   endfunction

   function automatic bit m_any_free();
      for (int i = 0; i < N; i++) if (!m_busy(i)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_gnt();
      return (m_lock || m_any_free()) ? 1 : 0;
   endfunction

   function automatic int m_id();
      if (m_lock) return m_lock_id;
      for (int i = 0; i < N; i++) if (!m_busy(i)) return i;
      return 0;
   endfunction

   function automatic int m_busy_vec();
      int v = 0;
      for (int i = 0; i < N; i++) if (m_busy(i)) v += (1 << i);
      return v;
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_busy(i)) c++;
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         nb[i] = 1'b0;
         nr[i] = 1'b0;
      end
      m_lock = 1'b0;
      m_lock_id = 0;
      m_err = 1'b0;
   endtask

   task automatic model_step(input bit rq, input bit hr, input bit ak,
                             input bit b, input int bi, input bit r, input int ri);
      bit g, a_ok, e, hb, hrr, ha, bad;
      int cid;
      g = m_gnt() != 0;
      cid = m_id();
      e = 1'b0;
      a_ok = ak && rq && g;
      if (ak && !a_ok) e = 1'b1;
      for (int i = 0; i < N; i++) begin
         hb  = b && (bi == i);
         hrr = r && (ri == i);
         ha  = a_ok && (cid == i);
         bad = (hb && !nb[i]) || (hrr && !nr[i]) || (ha && m_busy(i));
         if (bad) e = 1'b1;
         else if (ha) begin
            nb[i] = 1'b1;
            nr[i] = hr;
         end else begin
            if (hb)  nb[i] = 1'b0;
            if (hrr) nr[i] = 1'b0;
         end
      end
      if (ak || !rq) m_lock = 1'b0;
      else if (g) begin
         m_lock = 1'b1;
         m_lock_id = cid;
      end
      m_err = e;
   endtask

   task automatic check_all(input string tag);
      check_val({tag, "_gnt"}, int'(gnt), m_gnt());
      check_val({tag, "_id"}, int'(id), m_id());
      check_val({tag, "_busy"}, int'(busy), m_busy_vec());
      check_val({tag, "_outst"}, int'(outst), m_count());
      check_val({tag, "_err"}, int'(err), int'(m_err));
   endtask

   task automatic step(input bit rq, input bit hr, input bit ak,
                       input bit b, input int bi, input bit r, input int ri);
      req = rq; has_r = hr; ack = ak;
      bf = b; bid = 2'(bi); rf = r; rid = 2'(ri);
      @(posedge clk);
      #1;
      model_step(rq, hr, ak, b, bi, r, ri);
      check_all("step");
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic int pick_id(input bit want_b);
      int s = int'($urandom_range(N - 1));
      for (int k = 0; k < N; k++) begin
         int j = (s + k) % N;
         if (want_b ? nb[j] : nr[j]) return j;
      end
      return s;
   endfunction

   initial begin
      model_reset();
      #12;
      check_all("reset");
      rst_ni = 1'b1;

      // Allocate with R, then retire B then R.
      check_val("t1_id_at_ack", int'(id), 0);
      step(1, 1, 1, 0, 0, 0, 0);
      check_val("t1_busy", int'(busy), 4'b0001);
      check_val("t1_outst", int'(outst), 1);
      step(0, 0, 0, 1, 0, 0, 0);
      check_val("t1_busy_wait_r", int'(busy), 4'b0001);
      step(0, 0, 0, 0, 0, 1, 0);
      check_val("t1_busy_free", int'(busy), 0);

      // Stalled AW keeps ID 2 while slot 0 frees.
      step(1, 0, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0);
      check_val("t2_id_c0", int'(id), 2);
      step(1, 0, 0, 1, 0, 0, 0);
      check_val("t2_id_c1", int'(id), 2);
      step(1, 0, 0, 0, 0, 0, 0);
      check_val("t2_id_c2", int'(id), 2);
      step(1, 0, 1, 0, 0, 0, 0);
      check_val("t2_busy", int'(busy), 4'b0110);
      check_val("t2_next_id", int'(id), 0);
      step(0, 0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 2, 0, 0);

      // Full pool, then one slot returns.
      for (int k = 0; k < N; k++) step(1, 0, 1, 0, 0, 0, 0);
      check_val("t3_busy_full", int'(busy), 4'b1111);
      check_val("t3_gnt_full", int'(gnt), 0);
      step(0, 0, 0, 1, 2, 0, 0);
      check_val("t3_gnt", int'(gnt), 1);
      check_val("t3_id", int'(id), 2);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 3, 0, 0);

      // Simultaneous B and R retire a WAIT_BR slot at once.
      for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      check_val("t4_outst_before", int'(outst), 4);
      step(0, 0, 0, 1, 3, 1, 3);
      check_val("t4_outst_after", int'(outst), 3);
      check_val("t4_err", int'(err), 0);
      check_val("t4_busy", int'(busy), 4'b0111);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1, k, 0, 0);

      // Illegal events pulse err without touching state.
      step(1, 0, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      check_val("t5_err_r", int'(err), 1);
      check_val("t5_busy_r", int'(busy), 4'b0011);
      idle();
      check_val("t5_err_clear", int'(err), 0);
      step(0, 0, 1, 0, 0, 0, 0);
      check_val("t5_err_ack", int'(err), 1);
      check_val("t5_busy_ack", int'(busy), 4'b0011);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);

      // Asynchronous reset in the middle of a locked stall.
      for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      check_val("t6_busy_pre", int'(busy), 4'b0111);
      req = 0; ack = 0; bf = 0; rf = 0;
      #3;
      rst_ni = 1'b0;
      #1;
      model_reset();
      check_val("t6_gnt_rst", int'(gnt), 1);
      check_val("t6_id_rst", int'(id), 0);
      check_val("t6_busy_rst", int'(busy), 0);
      check_val("t6_outst_rst", int'(outst), 0);
      #2;
      rst_ni = 1'b1;
      check_val("t6_id_after", int'(id), 0);
      step(1, 1, 1, 0, 0, 0, 0);
      check_val("t6_busy_after", int'(busy), 4'b0001);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         bit rq, hr, ak, b, r;
         int bi, ri;
         rq = ($urandom_range(3) != 0);
         ak = rq ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
         hr = $urandom_range(1) != 0;
         b  = $urandom_range(2) == 0;
         r  = $urandom_range(2) == 0;
         bi = ($urandom_range(7) == 0) ? int'($urandom_range(N - 1)) : pick_id(1'b1);
         ri = ($urandom_range(7) == 0) ? int'($urandom_range(N - 1)) : pick_id(1'b0);
         step(rq, hr, ak, b, bi, r, ri);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
